// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-4 Booth multiplier, one digit per clock
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m_i,
    input  logic [WIDTH-1:0]     n_i,
    input  logic                 signed_i,
    input  logic                 abort_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p_o,
    output logic                 busy_o
);

    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int PW     = 2 * WIDTH + 2;
    localparam int NW     = WIDTH + 2;
    localparam int CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] ONE = PW'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    // Multiplicand pre-shifted by 2j, so the adder always sees an aligned operand.
    logic [PW-1:0]   mcand;
    // Multiplier shifted right by 2 per digit; its low two bits form the current triplet.
    logic [NW-1:0]   mplier;
    // Bit n[2j-1] carried over from the previous digit (0 for the first digit).
    logic            nprev;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [2:0]      trip;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;

    // Booth recoding of the current triplet and the single accumulator adder.
    always_comb begin
        trip   = {mplier[1:0], nprev};
        addend = '0;
        case (trip)
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = ~(mcand << 1) + ONE;
            3'b101, 3'b110: addend = ~mcand + ONE;
            default:        addend = '0;
        endcase
        sum = acc + addend;
    end

    // Control FSM and datapath registers; reset outranks abort and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
            p_o       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            nprev     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy_o   <= 1'b1;
                        mcand    <= {{(WIDTH + 2){signed_i & m_i[WIDTH-1]}}, m_i};
                        mplier   <= {{2{signed_i & n_i[WIDTH-1]}}, n_i};
                        nprev    <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy_o   <= 1'b0;
                    end else begin
                        acc    <= sum;
                        mcand  <= mcand << 2;
                        mplier <= mplier >> 2;
                        nprev  <= mplier[1];
                        cnt    <= cnt + CNT_ONE;
                        if (cnt == LAST) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            p_o       <= sum[2*WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    if (abort_i || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard testbench for booth_mul_seq
module tb_booth_mul_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   m_i = '0;
    logic [W-1:0]   n_i = '0;
    logic           signed_i = 1'b0;
    logic           abort_i = 1'b0;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p_o;
    logic           busy_o;

    logic           or_ctl = 1'b1;
    logic           rand_mode = 1'b0;
    logic           rnd_ready = 1'b1;

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] exp_q[$];

    assign out_ready = rand_mode ? rnd_ready : or_ctl;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m_i(m_i), .n_i(n_i), .signed_i(signed_i), .abort_i(abort_i),
        .out_valid(out_valid), .out_ready(out_ready), .p_o(p_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkp(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Random output backpressure, used only during the random phase.
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every product handed over must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_product: got 0x%08h with no operation outstanding", p_o);
            end else begin
                chkp("product", p_o, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] n, input logic s,
                         input logic ab, input logic push, input logic [2*W-1:0] e);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", t);
            return;
        end
        m_i = m; n_i = n; signed_i = s; abort_i = ab; in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort_i  = 1'b0;
        m_i      = W'($urandom);
        n_i      = W'($urandom);
        signed_i = ~s;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d products outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int t;
        logic [W-1:0] rm, rn;
        logic rs;
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0] pu;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chkp("rst_p_o", p_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: latency and most-negative squared
        issue(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 32'h40000000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk1("t1_busy", busy_o, 1'b1);
                chk1("t1_in_ready_calc", in_ready, 1'b0);
            end
            if (i == 9) chk1("t1_not_yet_valid", out_valid, 1'b0);
            if (i == 10) chk1("t1_valid_at_9", out_valid, 1'b1);
        end
        drain();

        // T2/T3: mode and sign corner cases
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFE0001);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 32'h00000001);
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
        issue(16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1, 32'hC0008000);
        issue(16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 32'h00000000);
        issue(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h7FFF8000);
        drain();

        // T4: backpressure holds the product; no acceptance while in DONE
        or_ctl = 1'b0;
        issue(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 32'h06260060);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1("t4_valid_seen", out_valid, 1'b1);
        m_i = 16'h0001; n_i = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t4_valid_held", out_valid, 1'b1);
            chkp("t4_p_held", p_o, 32'h06260060);
            chk1("t4_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        or_ctl   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("t4_idle_in_ready", in_ready, 1'b1);
        chk1("t4_idle_out_valid", out_valid, 1'b0);
        chkp("t4_p_kept", p_o, 32'h06260060);
        issue(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1, 32'h00000006);
        drain();

        // T5: abort at digit 4
        issue(16'h0007, 16'h0009, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_busy", busy_o, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        chk1("abort_no_valid", saw, 1'b0);

        // T5: reset at digit 6
        issue(16'h0007, 16'h0009, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_busy", busy_o, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chkp("midrst_p_o", p_o, 32'h0);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        chk1("midrst_no_valid", saw, 1'b0);
        issue(16'h0003, 16'hFFFB, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF1);
        drain();

        // abort together with in_valid in IDLE: accepted
        issue(16'h0010, 16'h0020, 1'b0, 1'b1, 1'b1, 32'h00000200);
        drain();

        // T6: random operands, both modes, random stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rm = W'($urandom);
            rn = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            ps = $signed(rm) * $signed(rn);
            pu = rm * rn;
            issue(rm, rn, rs, 1'b0, 1'b1, rs ? ps : pu);
        end
        drain();
        rand_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
